// File: rtl/ubb_pkg.sv
// Shared constants, state encoding and config field layout for the UBB
// timestamp modulator and its companion demodulator.
package ubb_pkg;

   localparam logic [15:0] UBB_SYNC_WORD  = 16'hEB90;
   localparam int          UBB_SYNC_BITS  = 16;
   localparam int          UBB_TIME_BITS  = 64;
   localparam int          UBB_FRAME_BITS = UBB_SYNC_BITS + UBB_TIME_BITS;

   // Config word layout
   localparam int CFG_SPC_LSB    = 0;
   localparam int CFG_SPC_MSB    = 15;
   localparam int CFG_INVERT_BIT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      DATA = 2'd2
   } ubb_state_t;

   // A samples-per-chip value of zero would stall the chip counter forever,
   // so it is treated as one.
   function automatic logic [15:0] ubb_eff_spc(input logic [15:0] spc);
      return (spc == 16'd0) ? 16'd1 : spc;
   endfunction

endpackage

// File: rtl/ubb_bpsk_mapper.sv
// BPSK sign mapper: passes the carrier sample through for a one chip and
// negates it (with saturation of the most negative code) for a zero chip.
module ubb_bpsk_mapper (
   input  logic [15:0] nco_i,
   input  logic        bit_val,
   input  logic        invert,
   output logic [15:0] sample
);

   logic [15:0] neg_sat;

   // Two's complement negate; -(-32768) would wrap, so clamp to +32767.
   always_comb begin
      if (nco_i == 16'h8000) begin
         neg_sat = 16'h7FFF;
      end else begin
         neg_sat = ~nco_i + 16'd1;
      end
      sample = (bit_val ^ invert) ? nco_i : neg_sat;
   end

endmodule

// File: rtl/ubb_modulator.sv
// BPSK timestamp modulator: frames a 64-bit time word behind the sync word
// and modulates it onto the incoming NCO carrier, one output per NCO sample.
module ubb_modulator
   import ubb_pkg::*;
#(
   parameter int S_AXIS_CONFIG_TDATA_WIDTH = 32,
   parameter int S_AXIS_TIME_TDATA_WIDTH   = 64,
   parameter int S_AXIS_NCO_TDATA_WIDTH    = 32,
   parameter int M_AXIS_TX_TDATA_WIDTH     = 16,
   parameter int M_AXIS_TX_TUSER_WIDTH     = 2
) (
   input  logic                                 aclk,
   input  logic                                 aresetn,
   input  logic [S_AXIS_CONFIG_TDATA_WIDTH-1:0] s_axis_config_tdata,
   input  logic                                 s_axis_config_tvalid,
   output logic                                 s_axis_config_tready,
   input  logic                                 s_axis_config_tlast,
   input  logic [S_AXIS_TIME_TDATA_WIDTH-1:0]   s_axis_time_tdata,
   input  logic                                 s_axis_time_tvalid,
   output logic                                 s_axis_time_tready,
   input  logic [S_AXIS_NCO_TDATA_WIDTH-1:0]    s_axis_nco_tdata,
   input  logic [1:0]                           s_axis_nco_tuser,
   input  logic                                 s_axis_nco_tlast,
   input  logic                                 s_axis_nco_tvalid,
   output logic                                 s_axis_nco_tready,
   output logic [M_AXIS_TX_TDATA_WIDTH-1:0]     m_axis_tx_tdata,
   output logic [M_AXIS_TX_TUSER_WIDTH-1:0]     m_axis_tx_tuser,
   output logic                                 m_axis_tx_tvalid,
   input  logic                                 m_axis_tx_tready,
   output logic                                 m_axis_tx_tlast
);

   localparam int SR_W = UBB_SYNC_BITS + S_AXIS_TIME_TDATA_WIDTH;

   ubb_state_t        state_reg, state_next;
   logic [15:0]       spc_reg;
   logic              invert_reg;
   logic [SR_W-1:0]   shift_reg;
   logic [6:0]        bit_cnt_reg;
   logic [15:0]       chip_cnt_reg;
   logic              ready_en_reg;

   logic [15:0]       tx_data_reg;
   logic [1:0]        tx_user_reg;
   logic              tx_last_reg;
   logic              tx_valid_reg;

   logic              config_fire, time_fire, nco_fire;
   logic              chip_wrap, last_sync_bit, last_bit;
   logic [15:0]       mapped;

   // Inputs that carry no information for this block.
   logic              unused_inputs;
   assign unused_inputs = ^{s_axis_config_tlast, s_axis_nco_tuser, s_axis_nco_tlast,
                            s_axis_nco_tdata[S_AXIS_NCO_TDATA_WIDTH-1:16],
                            s_axis_config_tdata[S_AXIS_CONFIG_TDATA_WIDTH-1:CFG_INVERT_BIT+1]};

   assign s_axis_config_tready = (state_reg == IDLE) && ready_en_reg;
   assign s_axis_time_tready   = (state_reg == IDLE) && ready_en_reg;
   assign s_axis_nco_tready    = (state_reg != IDLE) && (!tx_valid_reg || m_axis_tx_tready);

   assign config_fire   = s_axis_config_tvalid && s_axis_config_tready;
   assign time_fire     = s_axis_time_tvalid && s_axis_time_tready;
   assign nco_fire      = s_axis_nco_tvalid && s_axis_nco_tready;

   assign chip_wrap     = (chip_cnt_reg == spc_reg - 16'd1);
   assign last_sync_bit = (bit_cnt_reg == 7'(UBB_SYNC_BITS - 1));
   assign last_bit      = (bit_cnt_reg == 7'(UBB_FRAME_BITS - 1));

   assign m_axis_tx_tdata  = tx_data_reg;
   assign m_axis_tx_tuser  = tx_user_reg;
   assign m_axis_tx_tvalid = tx_valid_reg;
   assign m_axis_tx_tlast  = tx_last_reg;

   ubb_bpsk_mapper u_mapper (
      .nco_i   (s_axis_nco_tdata[15:0]),
      .bit_val (shift_reg[SR_W-1]),
      .invert  (invert_reg),
      .sample  (mapped)
   );

   // FSM state register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: sync bits, then payload bits, advancing on chip wraps.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (time_fire) state_next = SYNC;
         SYNC:    if (nco_fire && chip_wrap && last_sync_bit) state_next = DATA;
         DATA:    if (nco_fire && chip_wrap && last_bit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Ready gating so both input readys stay low for one cycle after reset.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ready_en_reg <= 1'b0;
      end else begin
         ready_en_reg <= 1'b1;
      end
   end

   // Config latch, frame shift register and chip/bit counters.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         spc_reg      <= 16'd1;
         invert_reg   <= 1'b0;
         shift_reg    <= '0;
         bit_cnt_reg  <= '0;
         chip_cnt_reg <= '0;
      end else begin
         if (config_fire) begin
            spc_reg    <= ubb_eff_spc(s_axis_config_tdata[CFG_SPC_MSB:CFG_SPC_LSB]);
            invert_reg <= s_axis_config_tdata[CFG_INVERT_BIT];
         end
         if (time_fire) begin
            shift_reg    <= {UBB_SYNC_WORD, s_axis_time_tdata};
            bit_cnt_reg  <= '0;
            chip_cnt_reg <= '0;
         end else if (nco_fire) begin
            if (chip_wrap) begin
               chip_cnt_reg <= '0;
               bit_cnt_reg  <= last_bit ? 7'd0 : bit_cnt_reg + 7'd1;
               shift_reg    <= {shift_reg[SR_W-2:0], 1'b0};
            end else begin
               chip_cnt_reg <= chip_cnt_reg + 16'd1;
            end
         end
      end
   end

   // Single output register stage; holds contents until the sink accepts.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         tx_valid_reg <= 1'b0;
         tx_data_reg  <= '0;
         tx_user_reg  <= '0;
         tx_last_reg  <= 1'b0;
      end else if (nco_fire) begin
         tx_valid_reg   <= 1'b1;
         tx_data_reg    <= mapped;
         tx_user_reg[0] <= (bit_cnt_reg == 7'd0) && (chip_cnt_reg == 16'd0);
         tx_user_reg[1] <= (bit_cnt_reg == 7'(UBB_SYNC_BITS)) && (chip_cnt_reg == 16'd0);
         tx_last_reg    <= last_bit && chip_wrap;
      end else if (m_axis_tx_tready) begin
         tx_valid_reg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ubb_modulator.sv
// Directed bench for ubb_modulator with a per-sample reference model.
module tb_ubb_modulator;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] cfg_tdata;
   logic        cfg_tvalid, cfg_tready, cfg_tlast;
   logic [63:0] time_tdata;
   logic        time_tvalid, time_tready;
   logic [31:0] nco_tdata;
   logic [1:0]  nco_tuser;
   logic        nco_tlast, nco_tvalid, nco_tready;
   logic [15:0] tx_tdata;
   logic [1:0]  tx_tuser;
   logic        tx_tvalid, tx_tready, tx_tlast;

   always #5 aclk = ~aclk;

   ubb_modulator dut (
      .aclk                 (aclk),
      .aresetn              (aresetn),
      .s_axis_config_tdata  (cfg_tdata),
      .s_axis_config_tvalid (cfg_tvalid),
      .s_axis_config_tready (cfg_tready),
      .s_axis_config_tlast  (cfg_tlast),
      .s_axis_time_tdata    (time_tdata),
      .s_axis_time_tvalid   (time_tvalid),
      .s_axis_time_tready   (time_tready),
      .s_axis_nco_tdata     (nco_tdata),
      .s_axis_nco_tuser     (nco_tuser),
      .s_axis_nco_tlast     (nco_tlast),
      .s_axis_nco_tvalid    (nco_tvalid),
      .s_axis_nco_tready    (nco_tready),
      .m_axis_tx_tdata      (tx_tdata),
      .m_axis_tx_tuser      (tx_tuser),
      .m_axis_tx_tvalid     (tx_tvalid),
      .m_axis_tx_tready     (tx_tready),
      .m_axis_tx_tlast      (tx_tlast)
   );

   typedef struct {
      logic [63:0] word;
      int          spc;
      bit          inv;
   } frame_t;

   frame_t      exp_q[$];
   int          checks = 0, failures = 0;
   int          sidx = 0, out_cnt = 0, nco_idx = 0, frames_done = 0;
   int          cyc = 0, last_nco_cyc = 0, hs_gap = 0;
   logic [15:0] nco_base = 16'h1000, nco_step = 16'h0000;
   bit          rand_nco = 0, rand_rdy = 0;
   int          cur_spc = 1;
   bit          cur_inv = 0;
   logic [15:0] held_data;
   logic [1:0]  held_user;
   logic        held_last;
   bit          stalled = 0;

   localparam logic [63:0] W0 = 64'h0123_4567_89AB_CDEF;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] neg_sat(input logic [15:0] x);
      if (x == 16'h8000) return 16'h7FFF;
      return 16'(-$signed(x));
   endfunction

   // NCO source and output sink; each may be randomly throttled.
   initial begin
      bit fire;
      nco_tvalid = 1'b0;
      nco_tdata  = '0;
      tx_tready  = 1'b1;
      forever begin
         @(negedge aclk);
         fire = aresetn && nco_tvalid && nco_tready;
         if (fire) last_nco_cyc = cyc;
         @(posedge aclk);
         cyc++;
         #1;
         if (fire) nco_idx++;
         nco_tvalid = rand_nco ? 1'($urandom_range(0, 1)) : 1'b1;
         nco_tdata  = {16'h0000, 16'(nco_base + nco_step * 16'(nco_idx))};
         tx_tready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor: stall stability plus per-sample comparison to the model.
   always @(negedge aclk) begin
      if (aresetn) begin
         if (stalled && tx_tvalid) begin
            check("stall_data", tx_tdata, held_data);
            check("stall_user", tx_tuser, held_user);
            check("stall_last", tx_tlast, held_last);
         end
         if (tx_tvalid && !tx_tready) begin
            held_data = tx_tdata;
            held_user = tx_tuser;
            held_last = tx_tlast;
            stalled   = 1;
         end else begin
            stalled = 0;
         end
         if (tx_tvalid && tx_tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_sample", 1, 0);
            end else begin
               frame_t      f;
               logic [79:0] fb;
               logic        b;
               logic [15:0] nco, e;
               f   = exp_q[0];
               fb  = {16'hEB90, f.word};
               b   = fb[79 - (sidx / f.spc)];
               nco = 16'(nco_base + nco_step * 16'(out_cnt));
               e   = (b ^ f.inv) ? nco : neg_sat(nco);
               check("sample_data", tx_tdata, e);
               check("sample_user", tx_tuser, {sidx == 16 * f.spc, sidx == 0});
               check("sample_last", tx_tlast, sidx == 80 * f.spc - 1);
               sidx++;
               out_cnt++;
               if (sidx == 80 * f.spc) begin
                  void'(exp_q.pop_front());
                  $display("frame %0d word=%h spc=%0d inv=%0d samples=%0d",
                           frames_done, f.word, f.spc, f.inv, sidx);
                  sidx = 0;
                  frames_done++;
               end
            end
         end
      end
   end

   task automatic new_test(input logic [15:0] base, input logic [15:0] step,
                           input bit rn, input bit rr);
      nco_base = base;
      nco_step = step;
      rand_nco = rn;
      rand_rdy = rr;
      out_cnt  = 0;
      nco_idx  = 0;
   endtask

   task automatic send_cfg(input logic [31:0] cfg);
      int n = 0;
      cfg_tdata  = cfg;
      cfg_tvalid = 1'b1;
      forever begin
         @(negedge aclk);
         if (cfg_tready) break;
         n++;
         if (n > 5000) begin
            check("cfg_timeout", 0, 1);
            break;
         end
      end
      cur_spc = (cfg[15:0] == 16'd0) ? 1 : int'(cfg[15:0]);
      cur_inv = cfg[16];
      @(posedge aclk);
      #1;
      cfg_tvalid = 1'b0;
   endtask

   task automatic offer(input bit with_cfg, input logic [31:0] cfg, input logic [63:0] word);
      int     n = 0;
      frame_t f;
      cfg_tvalid  = with_cfg;
      cfg_tdata   = cfg;
      time_tvalid = 1'b1;
      time_tdata  = word;
      forever begin
         @(negedge aclk);
         if (time_tready) break;
         n++;
         if (n > 5000) begin
            check("time_timeout", 0, 1);
            break;
         end
      end
      hs_gap = cyc - last_nco_cyc;
      if (with_cfg) begin
         check("cfg_with_time", cfg_tready, 1);
         cur_spc = (cfg[15:0] == 16'd0) ? 1 : int'(cfg[15:0]);
         cur_inv = cfg[16];
      end
      f.word = word;
      f.spc  = cur_spc;
      f.inv  = cur_inv;
      exp_q.push_back(f);
      @(posedge aclk);
      #1;
      cfg_tvalid  = 1'b0;
      time_tvalid = 1'b0;
   endtask

   task automatic wait_frames(input int target);
      int n = 0;
      while (frames_done < target) begin
         @(posedge aclk);
         #1;
         n++;
         if (n > 10000) begin
            check("frame_timeout", frames_done, target);
            break;
         end
      end
   endtask

   initial begin
      cfg_tdata   = '0;
      cfg_tvalid  = 1'b0;
      cfg_tlast   = 1'b0;
      time_tdata  = '0;
      time_tvalid = 1'b0;
      nco_tuser   = '0;
      nco_tlast   = 1'b0;

      // Reset state
      repeat (3) @(posedge aclk);
      #1;
      check("rst_cfg_rdy", cfg_tready, 0);
      check("rst_time_rdy", time_tready, 0);
      check("rst_nco_rdy", nco_tready, 0);
      check("rst_tvalid", tx_tvalid, 0);
      aresetn = 1'b1;
      #1;
      check("rel_time_rdy", time_tready, 0);
      @(posedge aclk);
      #1;
      check("idle_cfg_rdy", cfg_tready, 1);
      check("idle_time_rdy", time_tready, 1);
      check("idle_nco_rdy", nco_tready, 0);
      check("idle_tdata", tx_tdata, 0);
      check("idle_tuser", tx_tuser, 0);
      check("idle_tlast", tx_tlast, 0);

      // SPC=1, no invert; latency of the first sample
      new_test(16'h1000, 16'h0000, 0, 0);
      send_cfg(32'h0000_0001);
      offer(0, 32'h0, W0);
      check("sync_nco_rdy", nco_tready, 1);
      check("sync_tvalid", tx_tvalid, 0);
      check("sync_time_rdy", time_tready, 0);
      @(posedge aclk);
      #1;
      check("first_tvalid", tx_tvalid, 1);
      check("first_tuser", tx_tuser, 2'b01);
      check("first_tdata", tx_tdata, 16'h1000);
      wait_frames(1);
      check("count_spc1", out_cnt, 80);

      // SPC=4, inverted
      new_test(16'h1000, 16'h0000, 0, 0);
      send_cfg(32'h0001_0004);
      offer(0, 32'h0, W0);
      wait_frames(2);
      check("count_spc4", out_cnt, 320);

      // Saturation with SPC=0 (treated as 1)
      new_test(16'h8000, 16'h0000, 0, 0);
      send_cfg(32'h0000_0000);
      offer(0, 32'h0, 64'h0000_FFFF_0000_FFFF);
      @(posedge aclk);
      #1;
      check("sat_one", tx_tdata, 16'h8000);
      repeat (3) @(posedge aclk);
      #1;
      check("sat_zero", tx_tdata, 16'h7FFF);
      wait_frames(3);
      check("count_sat", out_cnt, 80);

      // Random stalls on both sides, ramping NCO data
      new_test(16'h0100, 16'h0001, 1, 1);
      send_cfg(32'h0000_0003);
      offer(0, 32'h0, 64'hA5C3_0F96_7E18_DB24);
      wait_frames(4);
      check("count_rand", out_cnt, 240);

      // Config with time together, then a second word queued mid-frame
      new_test(16'h1000, 16'h0000, 0, 0);
      offer(1, 32'h0000_0002, 64'hFEDC_BA98_7654_3210);
      repeat (20) @(posedge aclk);
      #1;
      check("busy_time_rdy", time_tready, 0);
      check("busy_cfg_rdy", cfg_tready, 0);
      offer(0, 32'h0, 64'h0F0F_F0F0_3C3C_C3C3);
      check("b2b_gap", hs_gap, 1);
      wait_frames(6);
      check("count_b2b", out_cnt, 320);

      // Reset mid-frame
      new_test(16'h1000, 16'h0000, 0, 0);
      send_cfg(32'h0000_0001);
      offer(0, 32'h0, W0);
      for (int n = 0; n < 1000 && sidx < 30; n++) begin
         @(posedge aclk);
         #1;
      end
      check("reached_s30", sidx >= 30, 1);
      aresetn = 1'b0;
      #1;
      check("abort_tvalid", tx_tvalid, 0);
      check("abort_tdata", tx_tdata, 0);
      check("abort_tlast", tx_tlast, 0);
      check("abort_tuser", tx_tuser, 0);
      check("abort_time_rdy", time_tready, 0);
      exp_q.delete();
      sidx    = 0;
      stalled = 0;
      cur_spc = 1;
      cur_inv = 0;
      new_test(16'h1000, 16'h0000, 0, 0);
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      check("rerel_time_rdy", time_tready, 1);
      offer(0, 32'h0, W0);
      @(posedge aclk);
      #1;
      check("fresh_tvalid", tx_tvalid, 1);
      check("fresh_tuser", tx_tuser, 2'b01);
      wait_frames(7);
      check("count_fresh", out_cnt, 80);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
